// File: rtl/sbilinear_window.sv
// 2x2 window feeder for the shift-based bilinear interpolator: one-line buffer,
// left-neighbour registers and per-frame half-pixel shift codes.
module sbilinear_window #(
  parameter int DATA_W = 16,
  parameter int SHW    = 6,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sof_in,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic [1:0]               phase_in,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] v00,
  output logic signed [DATA_W-1:0] v01,
  output logic signed [DATA_W-1:0] v10,
  output logic signed [DATA_W-1:0] v11,
  output logic [SHW-1:0]           s0,
  output logic [SHW-1:0]           s1,
  output logic [SHW-1:0]           s2,
  output logic [SHW-1:0]           s3,
  output logic                     eof_out
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {FIRST_ROW, ROWS, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            col, col_e;
  logic [RW-1:0]            row, row_e;
  logic [1:0]               phase_q;
  logic signed [DATA_W-1:0] lbuf [IMG_W];
  logic signed [DATA_W-1:0] rd, prev_left, cur_left;
  logic                     accept, last_col, last_row, win;

  // sof_in re-anchors the pixel it arrives with at (0,0), whatever the state
  always_comb begin
    accept   = valid_in && (sof_in || state != DONE);
    col_e    = sof_in ? '0 : col;
    row_e    = sof_in ? '0 : row;
    rd       = lbuf[col_e];
    last_col = (col_e == CW'(IMG_W-1));
    last_row = (row_e == RW'(IMG_H-1));
    win      = accept && (row_e != '0) && (col_e != '0);
  end

  // Read-before-write: rd carries the previous row's value at col_e
  always_ff @(posedge clk) begin
    if (accept) lbuf[col_e] <= pix_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FIRST_ROW;
      col       <= '0;
      row       <= '0;
      phase_q   <= '0;
      prev_left <= '0;
      cur_left  <= '0;
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      v00 <= '0; v01 <= '0; v10 <= '0; v11 <= '0;
      s0  <= '0; s1  <= '0; s2  <= '0; s3  <= '0;
    end else begin
      valid_out <= win;
      eof_out   <= win && (state == ROWS) && last_row && last_col;
      if (accept) begin
        // Left registers read as zero while col is 0, so nothing crosses a wrap
        prev_left <= last_col ? '0 : rd;
        cur_left  <= last_col ? '0 : pix_in;
        if (sof_in) phase_q <= phase_in;
        if (last_col) begin
          col <= '0;
          row <= (state == ROWS && !sof_in && last_row) ? '0 : row_e + 1'b1;
        end else begin
          col <= col_e + 1'b1;
          row <= row_e;
        end
        if (sof_in) state <= FIRST_ROW;
        else begin
          case (state)
            FIRST_ROW: if (last_col) state <= ROWS;
            ROWS:      if (last_col && last_row) state <= DONE;
            default:   state <= state;
          endcase
        end
      end
      if (win) begin
        v00 <= '0; v01 <= '0; v10 <= '0; v11 <= pix_in;
        s0  <= '0; s1  <= '0; s2  <= '0; s3  <= '0;
        case (phase_q)
          2'd1: begin
            v10 <= cur_left;
            s2  <= SHW'(1); s3 <= SHW'(1);
          end
          2'd2: begin
            v01 <= rd;
            s1  <= SHW'(1); s3 <= SHW'(1);
          end
          2'd3: begin
            v00 <= prev_left; v01 <= rd; v10 <= cur_left;
            s0  <= SHW'(2); s1 <= SHW'(2); s2 <= SHW'(2); s3 <= SHW'(2);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sbilinear_window.sv
// Directed bench for sbilinear_window with a 4x3 frame, pixel = 10*row + col.
module tb_sbilinear_window;
  localparam int DATA_W = 16;
  localparam int SHW    = 6;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 3;

  logic clk = 1'b0;
  logic rst, sof_in, valid_in;
  logic signed [DATA_W-1:0] pix_in;
  logic [1:0] phase_in;
  logic valid_out, eof_out;
  logic signed [DATA_W-1:0] v00, v01, v10, v11;
  logic [SHW-1:0] s0, s1, s2, s3;

  int n_chk  = 0;
  int n_fail = 0;
  int n_win  = 0;

  always #5 clk = ~clk;

  sbilinear_window #(.DATA_W(DATA_W), .SHW(SHW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .sof_in(sof_in), .valid_in(valid_in), .pix_in(pix_in),
    .phase_in(phase_in), .valid_out(valid_out),
    .v00(v00), .v01(v01), .v10(v10), .v11(v11),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .eof_out(eof_out)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel at frame position (r,c); live=0 means the DUT must ignore it
  task automatic send(input int r, input int c, input bit sof, input int ph, input bit live);
    int e00, e01, e10, e11, es0, es1, es2, es3;
    bit ew;
    valid_in = 1'b1;
    sof_in   = sof;
    pix_in   = DATA_W'(10*r + c);
    phase_in = 2'(ph);
    @(posedge clk); #1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
    ew = live && r >= 1 && c >= 1;
    chk($sformatf("vld(%0d,%0d)", r, c), int'(valid_out), int'(ew));
    chk($sformatf("eof(%0d,%0d)", r, c), int'(eof_out), int'(ew && r == IMG_H-1 && c == IMG_W-1));
    if (valid_out) n_win++;
    if (ew) begin
      e00 = 10*(r-1) + c-1; e01 = 10*(r-1) + c; e10 = 10*r + c-1; e11 = 10*r + c;
      case (ph)
        0: begin e00 = 0; e01 = 0; e10 = 0; es0 = 0; es1 = 0; es2 = 0; es3 = 0; end
        1: begin e00 = 0; e01 = 0; es0 = 0; es1 = 0; es2 = 1; es3 = 1; end
        2: begin e00 = 0; e10 = 0; es0 = 0; es1 = 1; es2 = 0; es3 = 1; end
        default: begin es0 = 2; es1 = 2; es2 = 2; es3 = 2; end
      endcase
      chk($sformatf("v00(%0d,%0d)", r, c), int'(v00), e00);
      chk($sformatf("v01(%0d,%0d)", r, c), int'(v01), e01);
      chk($sformatf("v10(%0d,%0d)", r, c), int'(v10), e10);
      chk($sformatf("v11(%0d,%0d)", r, c), int'(v11), e11);
      chk($sformatf("s0(%0d,%0d)", r, c), int'(s0), es0);
      chk($sformatf("s1(%0d,%0d)", r, c), int'(s1), es1);
      chk($sformatf("s2(%0d,%0d)", r, c), int'(s2), es2);
      chk($sformatf("s3(%0d,%0d)", r, c), int'(s3), es3);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("idle_vld", int'(valid_out), 0);
  endtask

  task automatic frame(input int ph, input bit use_sof, input bit gaps);
    n_win = 0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (gaps) while ($urandom_range(1) == 1) idle();
        send(r, c, use_sof && r == 0 && c == 0, ph, 1'b1);
      end
    chk("win_count", n_win, 6);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, int'(valid_out), 0);
    chk({tag, "_eof"}, int'(eof_out), 0);
    chk({tag, "_v"}, int'(v00) | int'(v01) | int'(v10) | int'(v11), 0);
    chk({tag, "_s"}, int'(s0) | int'(s1) | int'(s2) | int'(s3), 0);
  endtask

  initial begin
    rst = 1'b1; sof_in = 1'b0; valid_in = 1'b0; pix_in = '0; phase_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // 1: phase 3, continuous; last window held while valid_out is low
    frame(3, 1'b1, 1'b0);
    idle();
    chk("held_v00", int'(v00), 12);
    chk("held_v01", int'(v01), 13);
    chk("held_v10", int'(v10), 22);
    chk("held_v11", int'(v11), 23);
    chk("held_s0", int'(s0), 2);

    // 2: phase 0 and phase 1 frames
    frame(0, 1'b1, 1'b0);
    frame(1, 1'b1, 1'b0);

    // 3: phase 3 with random gaps
    frame(3, 1'b1, 1'b1);

    // 4: pixels after eof are ignored, then a phase 2 frame
    for (int i = 0; i < 3; i++) send(0, i, 1'b0, 3, 1'b0);
    frame(2, 1'b1, 1'b0);

    // 5: sof arrives where (1,2) would be; that pixel becomes (0,0)
    n_win = 0;
    for (int i = 0; i < IMG_W + 2; i++) send(i / IMG_W, i % IMG_W, i == 0, 3, 1'b1);
    chk("abort_wins", n_win, 1);
    frame(1, 1'b1, 1'b0);

    // 6: reset mid-row, then a frame without sof runs at phase 0
    for (int i = 0; i < IMG_W + 2; i++) send(i / IMG_W, i % IMG_W, i == 0, 3, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("mid_reset");
    frame(0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
